vip_gray_mean_binarize: RTL
===========================

Name: vip_gray_mean_binarize

Overview:
- Downstream consumer of the 3x3 gray median filter output. It turns the filtered 8-bit gray stream into a 1-bit-per-pixel binary image, emitted as 8'hFF or 8'h00.
- The threshold adapts per frame: each frame's mean gray value, plus a signed offset, becomes the threshold for the next frame.
- Mean is computed during vertical blanking by a multi-cycle restoring divider.

Parameters:
- CNT_W, 20, pixel-counter width (up to 2^20-1 pixels per frame).
- SUM_W, 28, gray-sum accumulator width (CNT_W+8).
- INIT_THRESH, 128, threshold used after reset until the first valid frame mean.
- TH_OFFSET, 0, signed 9-bit offset added to the mean before clamping to 0..255.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  async active-low reset.
- per_frame_vsync  in  1  frame-valid, high during frame.
- per_frame_href  in  1  line-valid.
- per_frame_clken  in  1  pixel-valid strobe.
- per_img_Y  in  8  filtered gray pixel.
- post_frame_vsync  out  1  per_frame_vsync delayed 1 cycle.
- post_frame_href  out  1  per_frame_href delayed 1 cycle.
- post_frame_clken  out  1  per_frame_clken delayed 1 cycle.
- post_img_Bit  out  8  8'hFF if pixel >= threshold, else 8'h00; forced 0 when post_frame_href is low.
- cur_thresh  out  8  threshold currently applied.
- thresh_update  out  1  one-cycle pulse when cur_thresh is loaded from a new mean.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except cur_thresh=INIT_THRESH. Accumulators are cleared, the FSM goes to IDLE, and the vsync edge register is cleared.
- Pixel path, 1-cycle latency. Registered: post_img_Bit = (per_img_Y >= cur_thresh) ? 8'hFF : 8'h00, sampled when per_frame_clken & per_frame_href. The sync signals are registered with the same 1-cycle delay. post_img_Bit holds its last value between clken strobes; it is gated to 0 while post_frame_href is low.
- Threshold switch: a cur_thresh change takes effect for the pixel in the cycle after thresh_update. It never changes mid-frame unless the divider finishes inside a frame (see overrun).
- Accumulation: on each cycle with per_frame_vsync & per_frame_href & per_frame_clken, sum += Y and cnt += 1.
- Counter saturation: when cnt reaches 2^CNT_W-1, both sum and cnt freeze for the rest of the frame. The mean is then computed over the first 2^CNT_W-1 pixels.
- Frame end is the falling edge of per_frame_vsync, detected with a 1-cycle registered copy. In that cycle:
  - the final sum and cnt, including any pixel accepted in that same cycle, are copied into divider operand registers;
  - the accumulators are cleared;
  - the FSM goes to DIV.
- FSM states:
  - IDLE: wait for frame end.
  - DIV: restoring division sum/cnt, one quotient bit per cycle, MSB first, for exactly SUM_W cycles. Quotient is truncated (floor).
  - UPD: 1 cycle. If quotient > 255, clamp to 255. Compute t = quotient + TH_OFFSET, clamped to 0..255. Load cur_thresh = t, pulse thresh_update, return to IDLE.
- Empty frame (cnt==0 at frame end): skip DIV. cur_thresh is unchanged, there is no thresh_update pulse, and the FSM stays in IDLE.
- Overrun (frame end while in DIV or UPD): the divider restarts in DIV with the new operands. The old result is discarded with no pulse.
- Divide time: DIV takes SUM_W+1 cycles from frame end to update. A vsync rising edge during DIV does not disturb the division; accumulation of the new frame proceeds in parallel.
- per_frame_clken without href is ignored for both accumulation and output.

Test Plan:
- Reset mid-DIV: assert rst_n=0 during the DIV state -> all outputs 0 immediately, cur_thresh=128, and no thresh_update after release; the next 4x4 frame of Y=100 yields a normal update to 100.
- Uniform frame: after reset, 4x4 frame with all Y=100 -> during frame post_img_Bit=8'h00 (100<128); thresh_update pulses SUM_W+1 cycles after vsync falls; cur_thresh=100.
- Next frame, with cur_thresh=100: pixels 99,100,101,0 -> post_img_Bit 00,FF,FF,00, each 1 cycle after its clken; zero outside href.
- Mean and offset clamping: 2x2 frame with Y={10,11,11,11} (sum 43, cnt 4) -> cur_thresh=10 (floor). Rebuilt with TH_OFFSET=-20 -> cur_thresh=0. With TH_OFFSET=+200 and all Y=255 -> cur_thresh=255.
- Empty frame: vsync high then low with no href or clken -> no thresh_update; cur_thresh holds its previous value.
- Overrun: two 1x1 frames (Y=50, then Y=200) whose vsync falls are 5 cycles apart -> exactly one thresh_update, with cur_thresh=200.

Source files
------------

// File: rtl/vip_gray_mean_binarize.sv
// vip_gray_mean_binarize
// Binarizes a filtered 8-bit gray stream against an adaptive threshold.
// Each frame's mean gray value, plus a signed offset, becomes the threshold
// for the following frame. The mean is produced during vertical blanking
// by a restoring divider that emits one quotient bit per clock.
module vip_gray_mean_binarize #(
    parameter int                 CNT_W       = 20,
    parameter int                 SUM_W       = 28,
    parameter int                 INIT_THRESH = 128,
    parameter logic signed [8:0]  TH_OFFSET   = 9'sd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_Bit,
    output logic [7:0] cur_thresh,
    output logic       thresh_update
);

    // Pixel counter saturates here; sum and count freeze for the rest of the frame.
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0] SUM_ZERO = {SUM_W{1'b0}};
    localparam logic [7:0]       INIT_TH  = 8'(INIT_THRESH);
    localparam int               DC_W     = $clog2(SUM_W + 1);
    localparam logic [DC_W-1:0]  DC_ZERO  = {DC_W{1'b0}};
    localparam logic [DC_W-1:0]  DC_ONE   = {{(DC_W-1){1'b0}}, 1'b1};
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_UPD  = 2'd2
    } state_t;

    // Clamp the quotient to 8 bits, add the signed offset, clamp to 0..255.
    // 11-bit two's complement covers -256..510 without overflow.
    function automatic logic [7:0] calc_thresh(input logic [SUM_W-1:0] quo);
        logic [7:0]  q_cl;
        logic [10:0] t_sum;
        logic [7:0]  res;
        if (quo > SUM_W'(255)) begin
            q_cl = 8'hFF;
        end else begin
            q_cl = quo[7:0];
        end
        t_sum = {3'b000, q_cl} + {{2{TH_OFFSET[8]}}, TH_OFFSET};
        if (t_sum[10]) begin
            res = 8'h00;
        end else if (t_sum[9:8] != 2'b00) begin
            res = 8'hFF;
        end else begin
            res = t_sum[7:0];
        end
        return res;
    endfunction

    // Registers
    logic             vsync_d_r;
    logic             post_vsync_r;
    logic             post_href_r;
    logic             post_clken_r;
    logic [7:0]       hold_r;
    logic [7:0]       bit_r;
    logic [SUM_W-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;
    logic [SUM_W-1:0] dvd_r;
    logic [CNT_W-1:0] dsr_r;
    logic [CNT_W:0]   rem_r;
    logic [SUM_W-1:0] quo_r;
    logic [DC_W-1:0]  div_cnt_r;
    logic [7:0]       cur_thresh_r;
    logic             thresh_update_r;

    // Combinational signals
    logic             pix_ok_s;
    logic             acc_ok_s;
    logic             frame_end_s;
    logic [SUM_W-1:0] sum_fin_s;
    logic [CNT_W-1:0] cnt_fin_s;
    logic [7:0]       pix_bit_s;
    logic [CNT_W+1:0] rem_sh_s;
    logic [CNT_W+1:0] diff_s;
    logic             sub_ok_s;
    logic [CNT_W:0]   rem_nx_s;

    // Pixel qualification, frame-end detection and final operand values.
    always_comb begin
        pix_ok_s    = per_frame_href & per_frame_clken;
        acc_ok_s    = per_frame_vsync & pix_ok_s & (cnt_r != CNT_MAX);
        frame_end_s = vsync_d_r & ~per_frame_vsync;
        if (acc_ok_s) begin
            sum_fin_s = sum_r + {{(SUM_W-8){1'b0}}, per_img_Y};
            cnt_fin_s = cnt_r + CNT_ONE;
        end else begin
            sum_fin_s = sum_r;
            cnt_fin_s = cnt_r;
        end
        if (per_img_Y >= cur_thresh_r) begin
            pix_bit_s = 8'hFF;
        end else begin
            pix_bit_s = 8'h00;
        end
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when the partial remainder is large enough.
    // The remainder is always below the divisor, so a negative difference
    // shows up as the top bit of the extended subtraction.
    always_comb begin
        rem_sh_s = {rem_r, dvd_r[SUM_W-1]};
        diff_s   = rem_sh_s - {2'b00, dsr_r};
        sub_ok_s = ~diff_s[CNT_W+1];
        if (sub_ok_s) begin
            rem_nx_s = diff_s[CNT_W:0];
        end else begin
            rem_nx_s = rem_sh_s[CNT_W:0];
        end
    end

    // Sync pipeline delay and vsync edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r    <= 1'b0;
            post_vsync_r <= 1'b0;
            post_href_r  <= 1'b0;
            post_clken_r <= 1'b0;
        end else begin
            vsync_d_r    <= per_frame_vsync;
            post_vsync_r <= per_frame_vsync;
            post_href_r  <= per_frame_href;
            post_clken_r <= per_frame_clken;
        end
    end

    // Binarized pixel: new value on each strobe, held between strobes,
    // zero whenever the delayed line-valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= 8'h00;
            bit_r  <= 8'h00;
        end else begin
            if (pix_ok_s) begin
                hold_r <= pix_bit_s;
            end else begin
                hold_r <= hold_r;
            end
            if (!per_frame_href) begin
                bit_r <= 8'h00;
            end else if (per_frame_clken) begin
                bit_r <= pix_bit_s;
            end else begin
                bit_r <= hold_r;
            end
        end
    end

    // Per-frame gray sum and pixel count; cleared at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= SUM_ZERO;
            cnt_r <= CNT_ZERO;
        end else if (frame_end_s) begin
            sum_r <= SUM_ZERO;
            cnt_r <= CNT_ZERO;
        end else begin
            sum_r <= sum_fin_s;
            cnt_r <= cnt_fin_s;
        end
    end

    // Mean FSM: launch the divider at frame end (restarting on overrun),
    // run SUM_W steps, then load the clamped threshold and pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            dvd_r           <= SUM_ZERO;
            dsr_r           <= CNT_ZERO;
            rem_r           <= {(CNT_W+1){1'b0}};
            quo_r           <= SUM_ZERO;
            div_cnt_r       <= DC_ZERO;
            cur_thresh_r    <= INIT_TH;
            thresh_update_r <= 1'b0;
        end else if (frame_end_s && (cnt_fin_s != CNT_ZERO)) begin
            state_r         <= ST_DIV;
            dvd_r           <= sum_fin_s;
            dsr_r           <= cnt_fin_s;
            rem_r           <= {(CNT_W+1){1'b0}};
            quo_r           <= SUM_ZERO;
            div_cnt_r       <= DC_ZERO;
            thresh_update_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    thresh_update_r <= 1'b0;
                end
                ST_DIV: begin
                    dvd_r           <= {dvd_r[SUM_W-2:0], 1'b0};
                    rem_r           <= rem_nx_s;
                    quo_r           <= {quo_r[SUM_W-2:0], sub_ok_s};
                    thresh_update_r <= 1'b0;
                    if (div_cnt_r == DC_LAST) begin
                        state_r <= ST_UPD;
                    end else begin
                        div_cnt_r <= div_cnt_r + DC_ONE;
                    end
                end
                ST_UPD: begin
                    cur_thresh_r    <= calc_thresh(quo_r);
                    thresh_update_r <= 1'b1;
                    state_r         <= ST_IDLE;
                end
                default: begin
                    state_r         <= ST_IDLE;
                    thresh_update_r <= 1'b0;
                end
            endcase
        end
    end

    assign post_frame_vsync = post_vsync_r;
    assign post_frame_href  = post_href_r;
    assign post_frame_clken = post_clken_r;
    assign post_img_Bit     = bit_r;
    assign cur_thresh       = cur_thresh_r;
    assign thresh_update    = thresh_update_r;

endmodule
